// File: rtl/enc_3b4b_stage.sv
// enc_3b4b_stage: 3B/4B sub-block encoder stage of an 8B/10B line encoder.
// Accepts {H,G,F} plus K/S/RD6 qualifiers and encodes them into the 4-bit fghj
// sub-block. The result goes into a 2-entry output FIFO with a ready/valid
// handshake on both sides. All state changes on the falling edge of clk.
//
// occupancy | meaning
// ----------+-----------------------------------------------
// EMPTY     | no entry buffered, out_valid low
// ONE       | one entry buffered, can accept and pop together
// FULL      | both entries buffered, in_ready low

module enc_3b4b_stage #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] data_in,
    input  logic       k_in,
    input  logic       s_in,
    input  logic       rd6,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] fghj,
    output logic       rd_out,
    output logic       k_out
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Entry layout: {fghj[3:0], rd_out, k_out}
    localparam int ENTRY_W = 6;

    logic [1:0]         occ;
    logic [1:0]         occ_nxt;
    logic               wptr;
    logic               rptr;
    logic               arm;
    logic               accept;
    logic               pop;
    logic [3:0]         enc_code;
    logic               enc_rd;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] head;

    // Data character code for one {H,G,F} value, chosen by running disparity.
    function automatic logic [3:0] data_code(input logic [2:0] hgf,
                                             input logic       alt,
                                             input logic       rd);
        logic [3:0] code;
        code = 4'b0000;
        case (hgf)
            3'b000:  code = rd ? 4'b0100 : 4'b1011;
            3'b001:  code = 4'b1001;
            3'b010:  code = 4'b0101;
            3'b011:  code = rd ? 4'b0011 : 4'b1100;
            3'b100:  code = rd ? 4'b0010 : 4'b1101;
            3'b101:  code = 4'b1010;
            3'b110:  code = 4'b0110;
            3'b111: begin
                // The alternate A7 form avoids a run of five equal bits
                // across the 6B/4B boundary when the S term says so.
                if (alt) begin
                    code = rd ? 4'b1000 : 4'b0111;
                end else begin
                    code = rd ? 4'b0001 : 4'b1110;
                end
            end
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    // Control (K) character code; the S term does not apply to K characters.
    function automatic logic [3:0] ctrl_code(input logic [2:0] hgf,
                                             input logic       rd);
        logic [3:0] code;
        code = 4'b0000;
        case (hgf)
            3'b000:  code = rd ? 4'b0100 : 4'b1011;
            3'b001:  code = rd ? 4'b1001 : 4'b0110;
            3'b010:  code = rd ? 4'b0101 : 4'b1010;
            3'b011:  code = rd ? 4'b0011 : 4'b1100;
            3'b100:  code = rd ? 4'b0010 : 4'b1101;
            3'b101:  code = rd ? 4'b1010 : 4'b0101;
            3'b110:  code = rd ? 4'b0110 : 4'b1001;
            3'b111:  code = rd ? 4'b1000 : 4'b0111;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    // Number of ones in a 4-bit code.
    function automatic logic [2:0] ones4(input logic [3:0] code);
        return {2'b00, code[3]} + {2'b00, code[2]}
             + {2'b00, code[1]} + {2'b00, code[0]};
    endfunction

    // Encode the offered symbol; a balanced code keeps the disparity.
    always_comb begin
        enc_code = 4'b0000;
        enc_rd   = 1'b0;
        if (k_in) begin
            enc_code = ctrl_code(data_in, rd6);
        end else begin
            enc_code = data_code(data_in, s_in, rd6);
        end
        enc_rd = (ones4(enc_code) == 3'd2) ? rd6 : ~rd6;
    end

    // Handshake qualifiers. in_ready depends only on registered state, so
    // there is no path from out_ready. While reset is held, in_ready reads 1.
    always_comb begin
        in_ready  = ~rst_n | (arm & (occ != OCC_FULL));
        out_valid = (occ == OCC_ONE) | (occ == OCC_FULL);
        accept    = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Next occupancy state.
    always_comb begin
        occ_nxt = occ;
        case (occ)
            OCC_EMPTY: begin
                if (accept) begin
                    occ_nxt = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && !pop) begin
                    occ_nxt = OCC_FULL;
                end else if (pop && !accept) begin
                    occ_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    occ_nxt = OCC_ONE;
                end
            end
            default: occ_nxt = OCC_EMPTY;
        endcase
    end

    // Accepts are held off until one falling edge has passed after reset
    // release, so the first accept lands no earlier than the second edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm <= 1'b0;
        end else begin
            arm <= 1'b1;
        end
    end

    // Occupancy and pointer update; pointers wrap naturally at 1 bit.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= OCC_EMPTY;
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            occ <= occ_nxt;
            if (accept) begin
                wptr <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
        end
    end

    // Entry storage. Entries are cleared on reset so the head reads zero
    // immediately and nothing stale can surface after release.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wptr] <= {enc_code, enc_rd, k_in};
        end
    end

    // Head entry drives the outputs.
    always_comb begin
        head   = mem[rptr];
        fghj   = head[5:2];
        rd_out = head[1];
        k_out  = head[0];
    end

endmodule

// File: tb/tb_enc_3b4b_stage.sv
// Testbench for enc_3b4b_stage: table-driven encoding checks while
// streaming, plus directed sequences for reset, backpressure and flush.

module tb_enc_3b4b_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] data_in;
    logic       k_in;
    logic       s_in;
    logic       rd6;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] fghj;
    logic       rd_out;
    logic       k_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       k;
        logic       s;
        logic       rd;
        logic [2:0] d;
        logic [3:0] exp_code;
        logic       exp_rd;
    } vec_t;

    vec_t vecs [20];

    enc_3b4b_stage #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .k_in      (k_in),
        .s_in      (s_in),
        .rd6       (rd6),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fghj      (fghj),
        .rd_out    (rd_out),
        .k_out     (k_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic k, input logic s, input logic rd, input logic [2:0] d);
        in_valid = v;
        k_in     = k;
        s_in     = s;
        rd6      = rd;
        data_in  = d;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_head(input string name, input logic [3:0] code, input logic rd, input logic k);
        check({name, "_valid"}, {7'd0, out_valid}, 8'd1);
        check({name, "_fghj"},  {4'd0, fghj},      {4'd0, code});
        check({name, "_rd"},    {7'd0, rd_out},    {7'd0, rd});
        check({name, "_k"},     {7'd0, k_out},     {7'd0, k});
    endtask

    initial begin
        //           k     s     rd    d       code     rd_out
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'b000, 4'b1011, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'b000, 4'b0100, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'b001, 4'b1001, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'b011, 4'b1100, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'b011, 4'b0011, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'b100, 4'b1101, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 3'b100, 4'b0010, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'b111, 4'b1110, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'b111, 4'b0001, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'b111, 4'b0111, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 3'b111, 4'b1000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 3'b010, 4'b0101, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b101, 4'b0101, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 3'b101, 4'b1010, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 3'b111, 4'b0111, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 3'b111, 4'b1000, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 3'b001, 4'b0110, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 3'b110, 4'b0110, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 3'b000, 4'b1011, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 3'b100, 4'b0010, 1'b0};

        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
        check("rst_in_ready",  {7'd0, in_ready},  8'd1);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_fghj",      {4'd0, fghj},      8'd0);
        check("rst_rd_out",    {7'd0, rd_out},    8'd0);
        check("rst_k_out",     {7'd0, k_out},     8'd0);

        repeat (2) @(negedge clk);
        @(posedge clk);
        rst_n = 1'b1;

        // Offer a symbol straight away; the first edge must not take it.
        out_ready = 1'b1;
        drive(1'b1, vecs[0].k, vecs[0].s, vecs[0].rd, vecs[0].d);
        step();
        check("first_edge_no_accept", {7'd0, out_valid}, 8'd0);
        check("first_edge_ready",     {7'd0, in_ready},  8'd1);

        // Streaming: accept and pop each edge, head is always the newest.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, vecs[i].k, vecs[i].s, vecs[i].rd, vecs[i].d);
            step();
            check_head($sformatf("vec%0d", i), vecs[i].exp_code, vecs[i].exp_rd, vecs[i].k);
            check($sformatf("vec%0d_in_ready", i), {7'd0, in_ready}, 8'd1);
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("drain_empty", {7'd0, out_valid}, 8'd0);

        // Backpressure: fill, hold a third symbol, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
        step();
        check_head("bp_first", 4'b1001, 1'b0, 1'b0);
        check("bp_ready_one", {7'd0, in_ready}, 8'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
        step();
        check_head("bp_full", 4'b1001, 1'b0, 1'b0);
        check("bp_ready_full", {7'd0, in_ready}, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
        step();
        check_head("bp_hold1", 4'b1001, 1'b0, 1'b0);
        check("bp_ready_hold", {7'd0, in_ready}, 8'd0);
        step();
        check_head("bp_hold2", 4'b1001, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        check_head("bp_second", 4'b0101, 1'b0, 1'b0);
        check("bp_ready_after_pop", {7'd0, in_ready}, 8'd1);
        step();
        check_head("bp_third", 4'b1100, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("bp_drained", {7'd0, out_valid}, 8'd0);

        // out_ready with nothing buffered must not disturb anything.
        step();
        check("idle_pop_valid", {7'd0, out_valid}, 8'd0);
        check("idle_pop_ready", {7'd0, in_ready},  8'd1);

        // Flush: fill the buffer, then assert reset between edges.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("flush_full", {7'd0, in_ready}, 8'd0);
        check_head("flush_head", 4'b0101, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("flush_out_valid", {7'd0, out_valid}, 8'd0);
        check("flush_in_ready",  {7'd0, in_ready},  8'd1);
        check("flush_fghj",      {4'd0, fghj},      8'd0);
        check("flush_k_out",     {7'd0, k_out},     8'd0);
        @(posedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_flush_empty1", {7'd0, out_valid}, 8'd0);
        step();
        check("post_flush_empty2", {7'd0, out_valid}, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b110);
        step();
        check_head("post_flush_sym", 4'b0110, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("post_flush_drained", {7'd0, out_valid}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
